// File: rtl/fifo_rd_burst.sv
// Drains len words from the async FIFO read port onto a valid/ready stream; word visible 1 rclk after its pop.
// Backpressure: m_ready low fills the 2-entry skid buffer, then rinc stops (rinc uses registered occupancy only).
module fifo_rd_burst #(
  parameter int DATA_SIZE = 8,
  parameter int LEN_W     = 8
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic                 rempty,
  output logic                 rinc,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LEN_W-1:0]     word_cnt,
  output logic [DATA_SIZE-1:0] xsum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [DATA_SIZE-1:0] buf0_q, buf0_d;
  logic [DATA_SIZE-1:0] buf1_q, buf1_d;
  logic [1:0]           count_q, count_d;
  logic                 done_q, done_d;
  logic [LEN_W-1:0]     word_cnt_q, word_cnt_d;
  logic [DATA_SIZE-1:0] xsum_q, xsum_d;
  logic                 push, pop;

  assign rinc     = (state_q == S_READ) && !rempty && (remaining_q != '0) && (count_q < 2'd2);
  assign push     = rinc;
  assign m_valid  = (count_q != 2'd0);
  assign pop      = m_valid && m_ready;
  assign m_data   = buf0_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign word_cnt = word_cnt_q;
  assign xsum     = xsum_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    count_d     = count_q;
    done_d      = 1'b0;
    word_cnt_d  = word_cnt_q;
    xsum_d      = xsum_q;

    if (pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
      xsum_d     = xsum_q ^ buf0_q;
    end

    // buf0 is always the head; simultaneous push/pop only happens at occupancy 1
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = rdata;
        else                 buf1_d = rdata;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: buf0_d = rdata;
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_cnt_d = '0;
          xsum_d     = '0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = S_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (push) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // done only once the final word is taken downstream
        if (pop && (count_q == 2'd1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      count_q     <= 2'd0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
      xsum_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      count_q     <= count_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
      xsum_q      <= xsum_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_burst.sv
// Bench for fifo_rd_burst: behavioural FIFO read port, scoreboard of expected output words.
module tb_fifo_rd_burst;

  logic       rclk = 1'b0;
  logic       wclk = 1'b0;
  logic       rrst_n;
  logic [7:0] rdata = 8'h00;
  logic       rempty = 1'b1;
  logic       rinc;
  logic       start;
  logic [7:0] len;
  logic       busy, done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] word_cnt;
  logic [7:0] xsum;

  fifo_rd_burst #(.DATA_SIZE(8), .LEN_W(8)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .start(start), .len(len), .busy(busy), .done(done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .word_cnt(word_cnt), .xsum(xsum)
  );

  always #15 rclk = ~rclk;
  always #10 wclk = ~wclk;

  int vectors = 0;
  int misc    = 0;

  logic [7:0] src[$];
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int wr_lim = 0;
  int wr_idx = 0;
  int rd_idx = 0;
  logic flush = 1'b0;

  int rinc_cnt = 0, rinc_run = 0, last_rinc_run = 0;
  int hs_cnt = 0, hs_run = 0, last_hs_run = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // write side: releases one preloaded word per wclk
  always @(posedge wclk) begin
    if (wr_idx < wr_lim) wr_idx <= wr_idx + 1;
  end

  // read side of the FIFO, first-word fall-through
  always @(posedge rclk) begin
    if (!rrst_n || flush) begin
      fq.delete();
      rd_idx = wr_idx;
      if (rinc_run > 0) last_rinc_run = rinc_run;
      rinc_run = 0;
    end else begin
      if (rinc) begin
        rinc_cnt++;
        rinc_run++;
        if (fq.size() > 0) void'(fq.pop_front());
      end else begin
        if (rinc_run > 0) last_rinc_run = rinc_run;
        rinc_run = 0;
      end
      while (rd_idx < wr_idx) begin
        fq.push_back(src[rd_idx]);
        rd_idx++;
      end
    end
    rempty <= (fq.size() == 0);
    rdata  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // monitor
  logic       stall_q = 1'b0;
  logic [7:0] stall_dat = 8'h00;
  initial forever begin
    logic [7:0] e;
    @(negedge rclk);
    if (rinc) check("rinc_while_empty", {31'd0, rempty}, 32'd0);
    if (stall_q && m_valid) check("m_data_stable", {24'd0, m_data}, {24'd0, stall_dat});
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        misc++;
        $display("FAIL unexpected_word: got %0h, none expected (t=%0t)", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("m_data", {24'd0, m_data}, {24'd0, e});
      end
      hs_cnt++;
      hs_run++;
    end else begin
      if (hs_run > 0) last_hs_run = hs_run;
      hs_run = 0;
    end
    stall_q   = m_valid && !m_ready && rrst_n;
    stall_dat = m_data;
    if (done) begin
      done_cnt++;
      check("done_after_last", exp_q.size(), 32'd0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input bit expect_out);
    src.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic do_start(input logic [7:0] l);
    @(posedge rclk); #1;
    start = 1'b1;
    len   = l;
    @(posedge rclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge rclk); #2;
      if (done_cnt != base) seen = 1'b1;
    end
    if (!seen) check("done_timeout", done_cnt - base, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rinc"},     {31'd0, rinc},    32'd0);
    check({tag, "_busy"},     {31'd0, busy},    32'd0);
    check({tag, "_done"},     {31'd0, done},    32'd0);
    check({tag, "_m_valid"},  {31'd0, m_valid}, 32'd0);
    check({tag, "_m_data"},   {24'd0, m_data},  32'd0);
    check({tag, "_word_cnt"}, {24'd0, word_cnt}, 32'd0);
    check({tag, "_xsum"},     {24'd0, xsum},    32'd0);
  endtask

  initial begin
    int rb, db, hb;
    bit hit;
    rrst_n = 1'b0; start = 1'b0; len = 8'd0; m_ready = 1'b0;
    #1;
    check_all_zero("reset");
    cycles(2);
    rrst_n = 1'b1;
    cycles(1);

    // three words, ready held high
    m_ready = 1'b1;
    push_word(8'h11, 1); push_word(8'h22, 1); push_word(8'h33, 1);
    wr_lim = src.size();
    cycles(4);
    rb = rinc_cnt; db = done_cnt;
    do_start(8'd3);
    wait_done(30);
    cycles(2);
    check("t1_rinc_cnt", rinc_cnt - rb, 32'd3);
    check("t1_rinc_run", last_rinc_run, 32'd3);
    check("t1_hs_run",   last_hs_run, 32'd3);
    check("t1_done_cnt", done_cnt - db, 32'd1);
    check("t1_word_cnt", {24'd0, word_cnt}, 32'd3);
    check("t1_xsum",     {24'd0, xsum}, 32'h00);
    check("t1_busy",     {31'd0, busy}, 32'd0);

    // backpressure: five words, ready low
    m_ready = 1'b0;
    push_word(8'h01, 1); push_word(8'h02, 1); push_word(8'h04, 1);
    push_word(8'h08, 1); push_word(8'h10, 1);
    wr_lim = src.size();
    cycles(6);
    rb = rinc_cnt; db = done_cnt;
    do_start(8'd5);
    cycles(8);
    check("t2_stall_rinc", rinc_cnt - rb, 32'd2);
    check("t2_buf_count",  {30'd0, dut.count_q}, 32'd2);
    check("t2_m_valid",    {31'd0, m_valid}, 32'd1);
    check("t2_m_data",     {24'd0, m_data}, 32'h01);
    check("t2_no_done",    done_cnt - db, 32'd0);
    m_ready = 1'b1;
    wait_done(30);
    cycles(2);
    check("t2_rinc_cnt", rinc_cnt - rb, 32'd5);
    check("t2_word_cnt", {24'd0, word_cnt}, 32'd5);
    check("t2_xsum",     {24'd0, xsum}, 32'h1F);
    check("t2_done_cnt", done_cnt - db, 32'd1);

    // start on an empty FIFO, words arrive later
    rb = rinc_cnt; db = done_cnt;
    do_start(8'd4);
    cycles(4);
    check("t3_idle_rinc", rinc_cnt - rb, 32'd0);
    check("t3_busy",      {31'd0, busy}, 32'd1);
    push_word(8'h5A, 1); push_word(8'hA5, 1); push_word(8'h3C, 1); push_word(8'h01, 1);
    wr_lim = src.size();
    wait_done(40);
    cycles(2);
    check("t3_rinc_cnt", rinc_cnt - rb, 32'd4);
    check("t3_word_cnt", {24'd0, word_cnt}, 32'd4);
    check("t3_xsum",     {24'd0, xsum}, 32'hC2);
    check("t3_done_cnt", done_cnt - db, 32'd1);

    // zero-length burst
    rb = rinc_cnt; db = done_cnt;
    do_start(8'd0);
    check("t4_done",     {31'd0, done}, 32'd1);
    check("t4_busy",     {31'd0, busy}, 32'd0);
    check("t4_word_cnt", {24'd0, word_cnt}, 32'd0);
    check("t4_xsum",     {24'd0, xsum}, 32'd0);
    cycles(3);
    check("t4_rinc_cnt", rinc_cnt - rb, 32'd0);
    check("t4_done_cnt", done_cnt - db, 32'd1);
    check("t4_done_low", {31'd0, done}, 32'd0);

    // second start while busy is ignored
    push_word(8'h71, 1); push_word(8'h72, 1);
    for (int i = 0; i < 7; i++) push_word(8'h90 + 8'(i), 0);
    wr_lim = src.size();
    cycles(10);
    rb = rinc_cnt; db = done_cnt;
    @(posedge rclk); #1;
    start = 1'b1; len = 8'd2;
    @(posedge rclk); #1;
    len = 8'd7;
    @(posedge rclk); #1;
    start = 1'b0;
    wait_done(30);
    cycles(4);
    check("t5_rinc_cnt", rinc_cnt - rb, 32'd2);
    check("t5_word_cnt", {24'd0, word_cnt}, 32'd2);
    check("t5_xsum",     {24'd0, xsum}, 32'h03);
    check("t5_done_cnt", done_cnt - db, 32'd1);
    check("t5_busy",     {31'd0, busy}, 32'd0);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;

    // reset in the middle of a 10-word burst
    for (int i = 0; i < 10; i++) push_word(8'h80 + 8'(i), 1);
    wr_lim = src.size();
    cycles(12);
    hb = hs_cnt;
    do_start(8'd10);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge rclk); #2;
      if (hs_cnt - hb >= 4) hit = 1'b1;
    end
    if (!hit) check("t6_hs_timeout", hs_cnt - hb, 32'd4);
    rrst_n = 1'b0;
    exp_q.delete();
    db = done_cnt;
    #1;
    check_all_zero("t6_mid_reset");
    cycles(2);
    rrst_n = 1'b1;
    cycles(3);
    check("t6_no_done", done_cnt - db, 32'd0);
    check("t6_busy",    {31'd0, busy}, 32'd0);

    // normal burst after reset
    push_word(8'h0F, 1); push_word(8'hF0, 1); push_word(8'h3C, 1);
    wr_lim = src.size();
    cycles(4);
    rb = rinc_cnt; db = done_cnt;
    do_start(8'd3);
    wait_done(30);
    cycles(2);
    check("t7_rinc_cnt", rinc_cnt - rb, 32'd3);
    check("t7_word_cnt", {24'd0, word_cnt}, 32'd3);
    check("t7_xsum",     {24'd0, xsum}, 32'hC3);
    check("t7_done_cnt", done_cnt - db, 32'd1);
    check("t7_exp_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/fifo_rd_burst.md
Name: fifo_rd_burst

Overview:
- Read-side consumer for the team's asynchronous FIFO (FIFO_TOP). It lives entirely in the read clock domain.
- On a start command it drains exactly len words through rinc/rdata/rempty and presents them on a valid/ready output stream.
- Buffering is a 2-entry registered skid buffer.
- It reports a per-burst word count, a per-burst XOR checksum, and a done pulse.

Parameters:
DATA_SIZE, 8, FIFO word width (matches FIFO_TOP DATA_SIZE)
LEN_W, 8, width of burst length and word counter

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  asynchronous active-low reset
rdata  input  DATA_SIZE  FIFO read data; valid whenever rempty=0 (first-word fall-through)
rempty  input  1  FIFO empty flag, rclk domain
rinc  output  1  FIFO pop strobe; pops rdata on the rclk edge where it is high
start  input  1  one-cycle burst request
len  input  LEN_W  burst length in words, sampled when start is accepted
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
m_data  output  DATA_SIZE  output stream data (head of skid buffer)
m_valid  output  1  output stream valid
m_ready  input  1  downstream ready
word_cnt  output  LEN_W  words accepted downstream in current/last burst
xsum  output  DATA_SIZE  XOR of all words accepted downstream in current/last burst

Behaviour:
Reset (rrst_n low, async):
- FSM returns to IDLE.
- rinc, busy, done, m_valid are 0; m_data, word_cnt and xsum are 0.
- remaining is cleared and the skid buffer is emptied.

Reset behaviour:
- Async assertion clears state immediately. Release is synchronous to rclk by the integrator's synchronizer.
- Reset mid-burst discards buffered words. Words already popped from the FIFO are lost; no recovery is attempted.

FSM states:
- IDLE: start=1 with len!=0 loads remaining=len, clears word_cnt and xsum, and moves to READ. start=1 with len=0 clears word_cnt and xsum and pulses done next cycle; state stays IDLE and busy stays 0.
- READ: issues pops. When remaining reaches 0 after a pop, move to FLUSH.
- FLUSH: waits for the skid buffer to empty. On the cycle the last word handshakes, go to IDLE and assert done for one cycle on the next edge.
- busy=1 in READ and FLUSH.
- start is ignored while busy=1.

Pop rule:
- rinc = (state==READ) && !rempty && (remaining!=0) && (buf_count<2).
- buf_count is the registered occupancy, so there is no combinational path from m_ready to rinc.
- On each rinc cycle, rdata is written into the buffer tail at the edge and remaining decrements.
- rinc is never asserted while rempty=1.

Skid buffer:
- 2 entries; m_data = head, m_valid = (buf_count!=0).
- Push and pop in the same cycle are allowed. buf_count is unchanged, and ordering is preserved (FIFO order).
- Latency: a word popped at edge N appears on m_data/m_valid after edge N.
- With m_ready held high and the FIFO non-empty, throughput is one word per rclk; buf_count holds at 1.
- m_data is stable while m_valid=1 and m_ready=0.

Counters:
- On each m_valid&&m_ready, word_cnt increments and xsum ^= m_data.
- Both hold their value after done until the next accepted start.
- word_cnt equals len at done; arithmetic wraps modulo 2^LEN_W, which is unreachable since len is at most 2^LEN_W-1.

Boundaries:
- rempty asserting mid-burst stalls pops; the burst resumes when rempty=0, with no word lost or duplicated.
- m_ready low fills the buffer to 2, then rinc deasserts.
- done fires only after every word has been accepted downstream, never merely at the last pop.

Test Plan:
- FIFO preloaded 0x11,0x22,0x33; start len=3, m_ready=1 -> rinc high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles; done one pulse; word_cnt=3, xsum=0x00; busy low after done.
- FIFO preloaded 5 words, m_ready=0, start len=5 -> exactly 2 rinc pulses then stall with buf_count=2 and m_data=word0 stable. Release m_ready -> remaining 3 words popped; order word0..word4; done after 5th handshake.
- FIFO empty; start len=4; write 4 words on wclk (20ns) while rclk=30ns -> no rinc while rempty=1; 4 words out in order; word_cnt=4; done once.
- start len=0 -> no rinc; done pulse next cycle; word_cnt=0, xsum=0; busy stays 0.
- start len=2 then start len=7 while busy -> second start ignored; exactly 2 pops; word_cnt=2.
- Burst len=10 with rrst_n pulsed low after 4 handshakes -> all outputs 0 immediately; no done pulse; a new start len=3 afterwards behaves normally from IDLE.
